// File: rtl/multi_channel_timestamper.sv
// Multi-channel edge timestamper: per-channel edge capture, round-robin
// arbitration into a first-word-fall-through FIFO drained by valid/ready.
//
// Ports:
//   clk, aresetn        clock, async active-low reset
//   ev_in[N_CH]         asynchronous event inputs
//   ch_enable[N_CH]     per-channel capture enable
//   edge_mode[2*N_CH]   per channel: 00 off, 01 rise, 10 fall, 11 both
//   counter_clear       pulse: timestamp counter -> 0
//   fifo_clear          pulse: flush FIFO, pending regs, overflow count
//   write_block         ignore new detections while high
//   intr_depth[CW]      interrupt threshold
//   out_valid/out_ready/out_data  stream {pol, ch[7:0], ts}
//   fifo_count, overflow_count, interrupt  status
module multi_channel_timestamper #(
  parameter int N_CH       = 4,
  parameter int TS_WIDTH   = 48,
  parameter int FIFO_DEPTH = 1024,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [N_CH-1:0]       ev_in,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [2*N_CH-1:0]     edge_mode,
  input  logic                  counter_clear,
  input  logic                  fifo_clear,
  input  logic                  write_block,
  input  logic [CW-1:0]         intr_depth,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TS_WIDTH+8:0]   out_data,
  output logic [CW-1:0]         fifo_count,
  output logic [15:0]           overflow_count,
  output logic                  interrupt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DW = TS_WIDTH + 9;

  logic [N_CH-1:0]     s1, s2, hist;
  logic [N_CH-1:0]     det, det_pol;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [N_CH-1:0]     pend_v, pend_pol;
  logic [TS_WIDTH-1:0] pend_ts [N_CH];
  logic [PW-1:0]       rr_ptr, rr_nxt;
  logic [N_CH-1:0]     gnt;
  logic                gnt_any;
  logic [7:0]          gnt_ch;
  logic                win_pol;
  logic [TS_WIDTH-1:0] win_ts;
  logic                xfer, can_accept;
  logic                wr_en, rd_en;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [16:0]         drop_sum, ovf_sum;
  logic [15:0]         ovf_nxt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1   <= '0;
      s2   <= '0;
      hist <= '0;
    end else begin
      s1   <= ev_in;
      s2   <= s1;
      hist <= s2;
    end
  end

  always_comb begin
    det     = '0;
    det_pol = '0;
    for (int k = 0; k < N_CH; k++) begin
      det_pol[k] = s2[k] & ~hist[k];
      det[k] = ~write_block & ch_enable[k]
             & (s2[k] ^ hist[k])
             & (s2[k] ? edge_mode[2*k]
                      : edge_mode[2*k+1]);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)          ts_cnt <= '0;
    else if (counter_clear) ts_cnt <= '0;
    else                   ts_cnt <= ts_cnt + 1'b1;
  end

  assign out_valid  = (fifo_count != '0);
  assign xfer       = out_valid & out_ready;
  assign can_accept = (fifo_count < CW'(FIFO_DEPTH)) | xfer;

  // First valid channel at or after rr_ptr, modulo N_CH.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    win_pol = 1'b0;
    win_ts  = '0;
    rr_nxt  = rr_ptr;
    if (can_accept && !fifo_clear) begin
      for (int i = 0; i < N_CH; i++) begin
        idx = (int'(rr_ptr) + i) % N_CH;
        if (!gnt_any && pend_v[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_ch   = 8'(idx);
          win_pol  = pend_pol[idx];
          win_ts   = pend_ts[idx];
          rr_nxt   = PW'((idx + 1) % N_CH);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rr_ptr <= '0;
    else          rr_ptr <= rr_nxt;
  end

  // A grant frees the slot in the same cycle, so a new hit never drops.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pend_v   <= '0;
      pend_pol <= '0;
      for (int k = 0; k < N_CH; k++) pend_ts[k] <= '0;
    end else if (fifo_clear) begin
      pend_v <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (det[k] && (!pend_v[k] || gnt[k])) begin
          pend_v[k]   <= 1'b1;
          pend_pol[k] <= det_pol[k];
          pend_ts[k]  <= ts_cnt;
        end else if (gnt[k]) begin
          pend_v[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int k = 0; k < N_CH; k++)
      drop_sum = drop_sum
               + 17'(det[k] & pend_v[k] & ~gnt[k]);
    ovf_sum = {1'b0, overflow_count} + drop_sum;
    ovf_nxt = (ovf_sum > 17'h0FFFF) ? 16'hFFFF
                                    : ovf_sum[15:0];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)       overflow_count <= '0;
    else if (fifo_clear) overflow_count <= '0;
    else                overflow_count <= ovf_nxt;
  end

  assign wr_en = gnt_any & ~fifo_clear;
  assign rd_en = xfer & ~fifo_clear;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {win_pol, gnt_ch, win_ts};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (fifo_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(wr_en)
                  - CW'(rd_en);
    end
  end

  // Gate the head so stale RAM contents never show on an empty FIFO.
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) interrupt <= 1'b0;
    else          interrupt <= (fifo_count > intr_depth);
  end

endmodule

// File: tb/tb_multi_channel_timestamper.sv
// Directed bench for multi_channel_timestamper.
// N_CH=4, TS_WIDTH=16, FIFO_DEPTH=4.
module tb_multi_channel_timestamper;

  localparam int N_CH = 4;
  localparam int TSW  = 16;
  localparam int FD   = 4;
  localparam int CW   = $clog2(FD) + 1;
  localparam int DW   = TSW + 9;

  logic            clk;
  logic            aresetn;
  logic [N_CH-1:0] ev_in;
  logic [N_CH-1:0] ch_enable;
  logic [7:0]      edge_mode;
  logic            counter_clear;
  logic            fifo_clear;
  logic            write_block;
  logic [CW-1:0]   intr_depth;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   fifo_count;
  logic [15:0]     overflow_count;
  logic            interrupt;

  int total = 0;
  int bad   = 0;

  multi_channel_timestamper #(
    .N_CH(N_CH), .TS_WIDTH(TSW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .aresetn(aresetn), .ev_in(ev_in),
    .ch_enable(ch_enable), .edge_mode(edge_mode),
    .counter_clear(counter_clear),
    .fifo_clear(fifo_clear),
    .write_block(write_block),
    .intr_depth(intr_depth),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_count(fifo_count),
    .overflow_count(overflow_count),
    .interrupt(interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // After this returns the counter reads 0; an edge
  // applied m ticks later is stamped with m+2.
  task automatic clear_ctr;
    counter_clear = 1'b1;
    tick();
    counter_clear = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) tick();
    total += 5;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", out_valid);
    end
    if (out_data !== '0) begin
      bad++; $display("FAIL rst_data got=%h want=0", out_data);
    end
    if (fifo_count !== '0) begin
      bad++; $display("FAIL rst_count got=%0d want=0", fifo_count);
    end
    if (overflow_count !== '0) begin
      bad++; $display("FAIL rst_ovf got=%0d want=0", overflow_count);
    end
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL rst_intr got=%b want=0", interrupt);
    end
    aresetn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_edge;
    edge_mode = 8'h01;
    clear_ctr();
    repeat (100) tick();
    ev_in[0] = 1'b1;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_early got=%b want=0", out_valid);
    end
    tick();
    total += 3;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL single_valid got=%b want=1", out_valid);
    end
    if (out_data !== {1'b1, 8'd0, 16'd102}) begin
      bad++;
      $display("FAIL single_data got=%h want=%h",
               out_data, {1'b1, 8'd0, 16'd102});
    end
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_count got=%0d want=1", fifo_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ev_in[0] = 1'b0;
    repeat (6) tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_fall got=%b want=0", out_valid);
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] order [4];
    order[0] = 8'd2; order[1] = 8'd3;
    order[2] = 8'd0; order[3] = 8'd1;
    edge_mode = 8'h55;
    // A lone ch1 event moves rr_ptr to 2.
    ev_in[1] = 1'b1;
    repeat (6) tick();
    total++;
    if (out_data[DW-2 -: 8] !== 8'd1) begin
      bad++; $display("FAIL sim_prep got=%0d want=1", out_data[DW-2 -: 8]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ev_in[1] = 1'b0;
    repeat (4) tick();
    clear_ctr();
    repeat (5) tick();
    ev_in = 4'hF;
    out_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 ||
          out_data !== {1'b1, order[i], 16'd7}) begin
        bad++;
        $display("FAIL sim_word%0d got=%b/%h want=1/%h", i,
                 out_valid, out_data, {1'b1, order[i], 16'd7});
      end
    end
    tick();
    total += 2;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL sim_drain got=%b want=0", out_valid);
    end
    if (overflow_count !== 16'd0) begin
      bad++; $display("FAIL sim_ovf got=%0d want=0", overflow_count);
    end
    out_ready = 1'b0;
    ev_in = 4'h0;
    repeat (4) tick();
  endtask

  task automatic test_overflow;
    edge_mode = 8'h0C;
    for (int i = 0; i < 10; i++) begin
      ev_in[1] = ~ev_in[1];
      repeat (2) tick();
    end
    repeat (6) tick();
    total += 3;
    if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count);
    end
    if (overflow_count !== 16'd5) begin
      bad++; $display("FAIL ovf_drops got=%0d want=5", overflow_count);
    end
    if (out_data[DW-1 -: 9] !== 9'h101) begin
      bad++; $display("FAIL ovf_head got=%h want=101", out_data[DW-1 -: 9]);
    end
    // The held pending word refills the slot freed by this read.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    total++;
    if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL ovf_pend got=%0d want=4", fifo_count);
    end
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    total += 3;
    if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL clr_count got=%0d want=0", fifo_count);
    end
    if (overflow_count !== 16'd0) begin
      bad++; $display("FAIL clr_ovf got=%0d want=0", overflow_count);
    end
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL clr_valid got=%b want=0", out_valid);
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap_and_clear;
    edge_mode = 8'h11;
    clear_ctr();
    repeat (16'hFFFD) tick();
    ev_in[0] = 1'b1;
    repeat (3) tick();
    ev_in[2] = 1'b1;
    repeat (8) tick();
    total += 3;
    if (fifo_count !== 3'd2) begin
      bad++; $display("FAIL wrap_count got=%0d want=2", fifo_count);
    end
    if (out_data !== {1'b1, 8'd0, 16'hFFFF}) begin
      bad++; $display("FAIL wrap_w0 got=%h want=%h",
                      out_data, {1'b1, 8'd0, 16'hFFFF});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (out_data !== {1'b1, 8'd2, 16'h0002}) begin
      bad++; $display("FAIL wrap_w1 got=%h want=%h",
                      out_data, {1'b1, 8'd2, 16'h0002});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ev_in = 4'h0;
    repeat (4) tick();
    clear_ctr();
    repeat (10) tick();
    ev_in[0] = 1'b1;
    repeat (2) tick();
    counter_clear = 1'b1;
    tick();
    counter_clear = 1'b0;
    ev_in[2] = 1'b1;
    repeat (6) tick();
    total += 2;
    if (out_data !== {1'b1, 8'd0, 16'd12}) begin
      bad++; $display("FAIL clr_same got=%h want=%h",
                      out_data, {1'b1, 8'd0, 16'd12});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (out_data !== {1'b1, 8'd2, 16'd2}) begin
      bad++; $display("FAIL clr_after got=%h want=%h",
                      out_data, {1'b1, 8'd2, 16'd2});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ev_in = 4'h0;
    repeat (4) tick();
  endtask

  task automatic test_mask_intr;
    edge_mode = 8'h01;
    write_block = 1'b1;
    ev_in[0] = 1'b1;
    repeat (6) tick();
    write_block = 1'b0;
    ev_in[0] = 1'b0;
    repeat (4) tick();
    edge_mode = 8'h00;
    ev_in[0] = 1'b1;
    repeat (6) tick();
    total += 2;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL mask_word got=%b want=0", out_valid);
    end
    if (overflow_count !== 16'd0) begin
      bad++; $display("FAIL mask_ovf got=%0d want=0", overflow_count);
    end
    edge_mode = 8'h55;
    ev_in = 4'h0;
    intr_depth = 3'd2;
    repeat (4) tick();
    ev_in = 4'b0111;
    repeat (6) tick();
    total += 2;
    if (fifo_count !== 3'd3) begin
      bad++; $display("FAIL intr_cnt3 got=%0d want=3", fifo_count);
    end
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL intr_early got=%b want=0", interrupt);
    end
    tick();
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL intr_rise got=%b want=1", interrupt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total += 2;
    if (fifo_count !== 3'd2 || interrupt !== 1'b1) begin
      bad++; $display("FAIL intr_lag got=%0d/%b want=2/1",
                      fifo_count, interrupt);
    end
    tick();
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL intr_fall got=%b want=0", interrupt);
    end
  endtask

  task automatic test_reset_mid;
    ev_in[3] = 1'b1;
    repeat (6) tick();
    total++;
    if (fifo_count !== 3'd3) begin
      bad++; $display("FAIL mid_prep got=%0d want=3", fifo_count);
    end
    aresetn = 1'b0;
    ev_in = 4'h0;
    #2;
    total += 4;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      bad++; $display("FAIL mid_stream got=%b/%h want=0/0",
                      out_valid, out_data);
    end
    if (fifo_count !== '0) begin
      bad++; $display("FAIL mid_count got=%0d want=0", fifo_count);
    end
    if (overflow_count !== '0) begin
      bad++; $display("FAIL mid_ovf got=%0d want=0", overflow_count);
    end
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL mid_intr got=%b want=0", interrupt);
    end
    repeat (3) tick();
    aresetn = 1'b1;
    repeat (3) tick();
    ev_in[1] = 1'b1;
    repeat (4) tick();
    total += 2;
    if (out_data !== {1'b1, 8'd1, 16'd5}) begin
      bad++; $display("FAIL mid_after got=%h want=%h",
                      out_data, {1'b1, 8'd1, 16'd5});
    end
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL mid_cnt got=%0d want=1", fifo_count);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    ev_in         = '0;
    ch_enable     = 4'hF;
    edge_mode     = '0;
    counter_clear = 1'b0;
    fifo_clear    = 1'b0;
    write_block   = 1'b0;
    intr_depth    = 3'd4;
    out_ready     = 1'b0;
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_overflow();
    test_wrap_and_clear();
    test_mask_intr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_timestamper.md
# multi_channel_timestamper

Parametrised successor to the single-input conversion timer. It timestamps edges on `N_CH` asynchronous event inputs against one free-running counter of width `TS_WIDTH`. Each channel has its own edge mode. Captured events are arbitrated round-robin into an on-chip synchronous FIFO, and software drains them through a valid/ready stream. Configuration arrives as plain ports from the surrounding IPIF register wrapper in the same clock domain.

## Interface
Parameters:
- `N_CH`, 4: number of event channels, 1..256.
- `TS_WIDTH`, 48: timestamp counter width, 16..64.
- `FIFO_DEPTH`, 1024: FIFO depth in words, power of two ≥ 4.
- `CW`, derived: `$clog2(FIFO_DEPTH)+1`, the width of the occupancy count.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: sole clock.
  - `aresetn` in 1: asynchronous active-low reset.
- Event inputs and per-channel configuration:
  - `ev_in` in N_CH: asynchronous event inputs.
  - `ch_enable` in N_CH: per-channel capture enable.
  - `edge_mode` in 2·N_CH: channel k uses bits [2k+1:2k]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- Control:
  - `counter_clear` in 1: single-cycle pulse that zeroes the timestamp counter.
  - `fifo_clear` in 1: single-cycle pulse that flushes the FIFO and pending registers and zeroes `overflow_count`.
  - `write_block` in 1: while high, new detections are ignored.
  - `intr_depth` in CW: interrupt threshold.
- Output stream:
  - `out_valid` out 1: stream word is valid.
  - `out_ready` in 1: consumer accepts the word.
  - `out_data` out TS_WIDTH+9: the stream word, laid out as {pol[1], ch[7:0], ts[TS_WIDTH-1:0]}. `pol` is 1 for a rising edge. `ch` is zero-extended.
- Status:
  - `fifo_count` out CW: FIFO occupancy.
  - `overflow_count` out 16: dropped-event count, saturating.
  - `interrupt` out 1: registered flag, high when `fifo_count > intr_depth`.

## Operation
- **Synchronisers.** Each `ev_in` bit passes through a 2-flop synchroniser, then a history flop.
- **Edge detection.**
  - A rising edge is sync=1 with history=0. A falling edge is the inverse.
  - A detection qualifies only if the channel is enabled, `edge_mode` selects that polarity, and `write_block` is 0.
- **Timestamp counter.**
  - Increments every cycle and wraps from 2^TS_WIDTH−1 to 0 silently.
  - `counter_clear` loads 0 on the next edge. Detections in the same cycle as the clear record the pre-clear value.
- **Pending registers.**
  - Each channel has a one-deep pending register holding {pol, ts, valid}.
  - A qualifying detection loads the register with the current counter value.
  - If the register is already valid and not granted this cycle, the new event is dropped and `overflow_count` increments, saturating at 0xFFFF.
  - Multiple channels dropping in the same cycle add their total to `overflow_count`, with saturation.
  - If the register is granted in the same cycle as a new detection, the new event loads: no drop.
- **Arbiter.**
  - Round-robin; grants at most one valid pending channel per cycle, and only if the FIFO can accept.
  - Search starts at `rr_ptr`. After a grant to channel k, `rr_ptr` becomes (k+1) mod N_CH.
  - `rr_ptr` is unchanged when nothing is granted.
- **FIFO.**
  - Synchronous and first-word-fall-through.
  - `out_valid` = not empty. A transfer happens when `out_valid && out_ready`.
  - "FIFO can accept" = `fifo_count < FIFO_DEPTH`, or a transfer happening that cycle.
  - When full, pending registers hold; events are dropped only at the pending stage.
- **`fifo_clear`.**
  - Overrides a write and a read in that cycle.
  - Next cycle: `fifo_count` = 0, all pending registers invalid, `overflow_count` = 0.
  - Does not affect the counter or `rr_ptr`.
- **Reset values.** While `aresetn` = 0, everything below is zero, with no counting:
  - `out_valid`, `out_data`, `fifo_count`, `overflow_count`, `interrupt`.
  - counter, `rr_ptr`, pending registers, synchroniser and history flops.

## Timing
- **Edge E** is the first clock edge at which `ev_in` presents the new level.
- **Capture path.**
  - Synchroniser output is valid after E+1; the history comparison is valid in the cycle after that.
  - The pending register loads at E+2 with the counter value present at that edge.
  - Channel-to-channel relative timestamps are exact; the absolute offset is a constant 2 cycles.
- **Earliest FIFO write:** E+3, on the grant the cycle after loading.
- **Earliest `out_valid`:** the cycle after the write, so minimum pin-to-`out_valid` latency is 4 cycles.
- **Updates after a write or read edge:**
  - `fifo_count` updates at that edge.
  - `interrupt` updates one cycle after `fifo_count`.
- **Throughput:** one event per cycle aggregate. A single channel sustains one event per 2 cycles without loss when the FIFO is not full.
- **Reset mid-operation:** asynchronous clear of all state. Outputs read 0 immediately. No partial word is ever presented after `aresetn` rises.

## Test plan
- **Single edge.** N_CH=4, ch0 rising only, counter cleared to 0. Raise `ev_in[0]` at E=100. Expect one word {1, 0, 102}; `out_valid` high at cycle 104.
- **Simultaneous edges.** Edges on all 4 channels in the same cycle, `rr_ptr`=2. Expect words in order ch2, ch3, ch0, ch1, all with identical ts, on consecutive cycles. `overflow_count` = 0.
- **Overflow.** ch1 both-edges, `out_ready`=0, FIFO_DEPTH=4. Toggle ch1 ten times, 2 cycles apart. Expect `fifo_count`=4, 1 pending, `overflow_count`=5. Then `fifo_clear`: count=0, overflow=0, `out_valid`=0.
- **Wrap-around and clear.**
  - TS_WIDTH=16, counter at 0xFFFE, event captured at 0xFFFF then another 3 cycles later. Expect ts 0xFFFF then 0x0002.
  - Event in the same cycle as `counter_clear` records the pre-clear value.
- **Masking and interrupt.**
  - Edges with `write_block`=1, or with `edge_mode`=00, produce no word and no overflow.
  - `intr_depth`=2: `interrupt` rises one cycle after the third word is written and falls one cycle after the count returns to 2.
- **Reset mid-burst.** Deassert `aresetn` with 3 words queued. Expect all outputs to read 0 asynchronously. After release, the first new edge yields ts relative to counter 0.
